// File: rtl/awgn_align_stage_pkg.sv
// Shared constants for the AWGN alignment stage: datapath defaults and
// saturating-counter geometry.
package awgn_align_stage_pkg;

  localparam int unsigned AAS_W     = 48;
  localparam int unsigned AAS_SW    = 6;
  localparam int unsigned SAT_CNT_W = 16;

  localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/awgn_align_stage_if.sv
// Valid/ready handshake bundle for the alignment stage.
// The upstream and downstream sides share this one bundle.
interface awgn_align_stage_if
  import awgn_align_stage_pkg::*;
#(
  parameter int unsigned W = AAS_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_mant;
  logic [7:0]   in_exp;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_sticky;

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_data, out_sticky
  );

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_data, out_sticky
  );

endinterface

// File: rtl/barrel_shifter_48_right.sv
// Logarithmic right barrel shifter with zero fill.
// Shift amounts of W or more produce zero.
module barrel_shifter_48_right
  import awgn_align_stage_pkg::*;
#(
  parameter int unsigned W  = AAS_W,
  parameter int unsigned SW = AAS_SW
) (
  input  logic [W-1:0]  i_data,
  input  logic [SW-1:0] i_shamt,
  output logic [W-1:0]  o_data
);

  logic [W-1:0] w_stage;

  always_comb begin
    w_stage = i_data;
    for (int unsigned k = 0; k < SW; k++) begin
      if (i_shamt[k]) begin
        w_stage = w_stage >> (1 << k);
      end
    end
    o_data = w_stage;
  end

endmodule

// File: rtl/awgn_align_stage.sv
// Two-stage elastic pipeline that right-aligns a mantissa by an exponent,
// collecting shifted-out bits into a sticky flag and counting saturating shifts.
module awgn_align_stage
  import awgn_align_stage_pkg::*;
#(
  parameter int unsigned W  = AAS_W,
  parameter int unsigned SW = AAS_SW
) (
  input  logic                 clk,
  input  logic                 reset,
  awgn_align_stage_if.slave    bus,
  output logic [SAT_CNT_W-1:0] sat_count
);

  localparam logic [7:0]   W_EXP = 8'(W);
  localparam logic [W-1:0] ONES  = '1;

  logic                 r_s1_valid;
  logic [W-1:0]         r_s1_mant;
  logic [SW-1:0]        r_s1_shift;
  logic                 r_s1_sat;
  logic                 r_s1_sticky_all;

  logic                 r_s2_valid;
  logic [W-1:0]         r_s2_data;
  logic                 r_s2_sticky;

  logic [SAT_CNT_W-1:0] r_sat_count;

  logic                 w_s2_free;
  logic                 w_s1_free;
  logic                 w_in_sat;
  logic                 w_accept;
  logic [W-1:0]         w_shifted;
  logic [W-1:0]         w_mask;
  logic                 w_sticky;

  // Ready depends only on register state and out_ready, never on in_valid.
  assign w_s2_free = !r_s2_valid || bus.out_ready;
  assign w_s1_free = !r_s1_valid || w_s2_free;
  assign w_in_sat  = (bus.in_exp >= W_EXP);
  assign w_accept  = bus.in_valid && w_s1_free;

  assign bus.in_ready = w_s1_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid      <= 1'b0;
      r_s1_mant       <= '0;
      r_s1_shift      <= '0;
      r_s1_sat        <= 1'b0;
      r_s1_sticky_all <= 1'b0;
    end else if (w_s1_free) begin
      r_s1_valid      <= bus.in_valid;
      r_s1_mant       <= bus.in_mant;
      r_s1_shift      <= w_in_sat ? '0 : bus.in_exp[SW-1:0];
      r_s1_sat        <= w_in_sat;
      r_s1_sticky_all <= |bus.in_mant;
    end
  end

  barrel_shifter_48_right #(
    .W  (W),
    .SW (SW)
  ) u_shift (
    .i_data  (r_s1_mant),
    .i_shamt (r_s1_shift),
    .o_data  (w_shifted)
  );

  assign w_mask   = ~(ONES << r_s1_shift);
  assign w_sticky = |(r_s1_mant & w_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid  <= 1'b0;
      r_s2_data   <= '0;
      r_s2_sticky <= 1'b0;
    end else if (w_s2_free) begin
      r_s2_valid  <= r_s1_valid;
      r_s2_data   <= r_s1_sat ? '0 : w_shifted;
      r_s2_sticky <= r_s1_sat ? r_s1_sticky_all : w_sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat_count <= '0;
    end else if (w_accept && w_in_sat && (r_sat_count != SAT_CNT_MAX)) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

  assign bus.out_valid  = r_s2_valid;
  assign bus.out_data   = r_s2_data;
  assign bus.out_sticky = r_s2_sticky;
  assign sat_count      = r_sat_count;

endmodule

// File: tb/tb_awgn_align_stage.sv
// Scoreboard bench for awgn_align_stage: expected results are queued on
// input acceptance and checked in order against every output beat.
module tb_awgn_align_stage;

  typedef struct packed {
    logic [47:0] d;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sat_count;
  logic        rand_en = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_out    = 0;
  int unsigned cyc      = 0;
  int unsigned inflight = 0;
  logic [15:0] m_sat    = '0;
  exp_t        q[$];

  awgn_align_stage_if #(.W(48)) bus ();

  awgn_align_stage #(.W(48), .SW(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [47:0] m, input logic [7:0] e);
    exp_t r;
    if (e >= 8'd48) begin
      r.d = '0;
      r.s = (m != 48'd0);
    end else begin
      r.d = m >> e;
      r.s = ((r.d << e) != m);
    end
    return r;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    bit acc_in;
    bit acc_out;
    if (reset) begin
      q.delete();
      inflight = 0;
      m_sat    = '0;
    end else begin
      chk("in_ready", 64'(bus.in_ready), 64'(!(inflight == 2 && !bus.out_ready)));
      chk("sat_count", 64'(sat_count), 64'(m_sat));
      acc_out = bus.out_valid && bus.out_ready;
      acc_in  = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'(bus.out_valid), 64'(0));
        end else begin
          chk("out_data", 64'(bus.out_data), 64'(q[0].d));
          chk("out_sticky", 64'(bus.out_sticky), 64'(q[0].s));
          if (bus.out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (acc_in) begin
        q.push_back(model(bus.in_mant, bus.in_exp));
        if (bus.in_exp >= 8'd48 && m_sat != 16'hFFFF) m_sat = m_sat + 16'd1;
      end
      inflight = inflight + int'(acc_in) - int'(acc_out);
    end
  end

  always @(posedge clk) begin
    if (rand_en) begin
      #1 bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [47:0] m, input logic [7:0] e);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mant  = m;
    bus.in_exp   = e;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    chk("send_accept", 64'(acc), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t required completion", $time);
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    int unsigned n0;
    logic [47:0] rm;
    logic [7:0]  re;

    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_sticky", 64'(bus.out_sticky), 64'(0));
    chk("rst_sat_count", 64'(sat_count), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Basic alignment and two-cycle latency.
    bus.out_ready = 1'b1;
    send(48'h0000_0000_00FF, 8'd4);
    @(negedge clk);
    chk("lat_cycle1", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    chk("lat_cycle2", 64'(bus.out_valid), 64'(1));
    chk("lat_data", 64'(bus.out_data), 64'(48'h0000_0000_000F));
    chk("lat_sticky", 64'(bus.out_sticky), 64'(1));
    @(posedge clk);
    #1;
    drain();

    send(48'h8000_0000_0000, 8'd47);
    send(48'h8000_0000_0000, 8'd0);
    drain();

    // Saturating shifts.
    send(48'd1, 8'd48);
    send(48'd1, 8'd200);
    drain();
    chk("sat_two", 64'(sat_count), 64'(2));
    send(48'd0, 8'd60);
    drain();

    // Back-to-back throughput.
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(48'h1234_5678_9ABC + 48'(i), 8'(i * 5));
    chk("throughput_cycles", 64'(cyc - t0), 64'(8));
    drain();

    // Random backpressure stream.
    n0 = n_out;
    rand_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rm = {16'($urandom), 32'($urandom)};
      re = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(48, 255)) : 8'($urandom_range(0, 47));
      send(rm, re);
    end
    drain();
    rand_en = 1'b0;
    @(posedge clk);
    #3 bus.out_ready = 1'b1;
    chk("rand_count", 64'(n_out - n0), 64'(10));

    // Reset with both stages full.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(48'd5, 8'd100);
    send(48'd7, 8'd50);
    @(negedge clk);
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    chk("full_out_valid", 64'(bus.out_valid), 64'(1));
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_sat_count", 64'(sat_count), 64'(0));
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Counter saturation from just below the ceiling.
    @(posedge clk);
    #2 force dut.r_sat_count = 16'hFFFE;
    m_sat = 16'hFFFE;
    #1 release dut.r_sat_count;
    @(posedge clk);
    #1;
    send(48'hF, 8'd100);
    send(48'hF, 8'd255);
    send(48'hF, 8'd48);
    drain();
    chk("sat_hold", 64'(sat_count), 64'(16'hFFFF));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/awgn_align_stage.md
AWGN_ALIGN_STAGE -- requirements
Module: awgn_align_stage

Interface
- REQ-001 Parameter W, default 48: datapath width in bits.
- REQ-002 Parameter SW, default 6: width of the shift-amount field passed to the shifter.
- REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-004 Port reset, input, 1: synchronous, active-high reset.
- REQ-005 Port in_valid, input, 1: in_mant/in_exp are valid this cycle.
- REQ-006 Port in_ready, output, 1: stage accepts input this cycle.
- REQ-007 Port in_mant, input, W: unsigned mantissa to align.
- REQ-008 Port in_exp, input, 8: unsigned right-shift request, range 0..255.
- REQ-009 Port out_valid, output, 1: out_data/out_sticky are valid.
- REQ-010 Port out_ready, input, 1: downstream accepts output this cycle.
- REQ-011 Port out_data, output, W: in_mant shifted right by the clamped amount, zero-filled.
- REQ-012 Port out_sticky, output, 1: OR of all bits shifted out.
- REQ-013 Port sat_count, output, 16: count of accepted inputs with in_exp >= W.

Function
- REQ-014 Transfer occurs only when valid and ready are both high on the same edge, on both sides.
- REQ-015 Pipeline has two register stages, S1 and S2, each holding a valid bit.
- REQ-016 S1 captures in_mant, the clamped shift, a saturate flag (in_exp >= W), and a sticky-all bit (|in_mant).
- REQ-017 Clamped shift is in_exp when in_exp < W; otherwise the shift field is don't-care and the saturate flag governs.
- REQ-018 S2 captures the shifter output and sticky, driven from S1 contents.
- REQ-019 When not saturated, S2 data = S1 mant >> shift and sticky = |(S1 mant & ((1<<shift)-1)).
- REQ-020 When saturated, S2 data = 0 and sticky = S1 sticky-all.
- REQ-021 Shift 0 passes the mantissa unchanged with sticky = 0.
- REQ-022 s2_free = !S2.valid || out_ready.
- REQ-023 s1_free = !S1.valid || s2_free.
- REQ-024 in_ready = s1_free, a combinational function of register state and out_ready only.
- REQ-025 S2 loads from S1 whenever s2_free; S2.valid takes S1.valid.
- REQ-026 S1 loads from the input whenever s1_free; S1.valid takes in_valid.
- REQ-027 Latency is 2 cycles from input accept to out_valid when out_ready is held high.
- REQ-028 Throughput is 1 item/cycle with no bubbles under continuous valid/ready.
- REQ-029 While out_valid && !out_ready, out_data, out_sticky and out_valid stay stable.
- REQ-030 Items are never dropped or duplicated.
- REQ-031 sat_count increments on each accepted input with in_exp >= W.
- REQ-032 sat_count saturates at 16'hFFFF; it never wraps.
- REQ-033 out_data, out_sticky and out_valid come directly from S2 registers.

Reset
- REQ-034 While reset is high, on each clk edge: S1.valid = 0, S2.valid = 0, out_data = 0, out_sticky = 0, sat_count = 0.
- REQ-035 In-flight items are discarded when reset asserts mid-operation.
- REQ-036 in_ready is high in the first cycle after reset deasserts.
- REQ-037 Reset has priority over any simultaneous transfer.

Structure
- REQ-038 A shared package holds the W and SW defaults, the sat_count width (16) and the saturation constant 16'hFFFF.
- REQ-039 The right shift is a single instance of barrel_shifter_48_right placed between S1 and S2.
- REQ-040 Sticky mask logic and the saturate mux stay local to awgn_align_stage.

Verification
- REQ-041 mant=48'h0000_0000_00FF, exp=4, out_ready=1 -> 2 cycles later out_data=48'h0000_0000_000F, sticky=1.
- REQ-042 mant=48'h8000_0000_0000, exp=47 -> out_data=1, sticky=0; exp=0 -> data unchanged, sticky=0.
- REQ-043 exp=48, then exp=200, mant=1 -> out_data=0, sticky=1 for both; sat_count=2; mant=0, exp=60 -> sticky=0.
- REQ-044 Stream 10 items with out_ready toggling randomly -> all 10 items in order, outputs stable while stalled, in_ready low only when both stages are full and out_ready=0.
- REQ-045 Reset asserted with both stages full -> out_valid=0 next cycle, sat_count=0, no stale item emitted.
- REQ-046 Force sat_count to 16'hFFFE, accept 3 saturating items -> sat_count holds at 16'hFFFF.
